i2c_master_ctrl: RTL and testbench

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

---
 rtl/i2c_pkg.sv | 36 +++
 rtl/i2c_qtr_tick.sv | 36 +++
 rtl/i2c_master_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master controller.
// Optional read path is enabled by defining I2C_MASTER_READ_EN.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      START,
      ADDR,
      ACK_ADDR,
      REG,
      ACK_REG,
      WDATA,
      ACK_WDATA,
`ifdef I2C_MASTER_READ_EN
      RESTART,
      ADDR_RD,
      ACK_ADDR_RD,
      RDATA,
      MNACK,
`endif
      STOP
   } i2c_state_t;

   typedef enum logic [1:0] {
      Q0,
      Q1,
      Q2,
      Q3
   } qtr_phase_t;

   // Slave address used when a command carries the general 7'h00 address
   localparam logic [6:0] ADDR_DEFAULT = 7'h55;
   localparam logic [6:0] ADDR_GENERAL = 7'h00;
   localparam logic       RW_READ      = 1'b1;

endpackage

// File: rtl/i2c_qtr_tick.sv
// Quarter-period strobe and 2-bit phase generator for SCL timing.
// Held cleared whenever en is low so every transaction starts in Q0.
module i2c_qtr_tick
   import i2c_pkg::*;
#(
   parameter int QTR_DIV = 250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   output logic       tick,
   output qtr_phase_t phase
);

   localparam int CW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(QTR_DIV - 1);

   logic [CW-1:0] cnt_reg;
   qtr_phase_t    phase_reg;

   always_ff @(posedge clk) begin
      if (reset || !en) begin
         cnt_reg   <= '0;
         phase_reg <= Q0;
      end else if (cnt_reg == CNT_LAST) begin
         cnt_reg   <= '0;
         phase_reg <= qtr_phase_t'(phase_reg + 2'd1);
      end else begin
         cnt_reg   <= cnt_reg + 1'b1;
      end
   end

   assign tick  = en && (cnt_reg == CNT_LAST);
   assign phase = phase_reg;

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-register I2C master: write reg/data, or (with I2C_MASTER_READ_EN)
// read one byte via repeated START. SCL/SDA are registered; SDA is open-drain.
module i2c_master_ctrl
   import i2c_pkg::*;
#(
   parameter int         QTR_DIV        = 250,
   parameter logic [6:0] DEF_SLAVE_ADDR = ADDR_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_start,
   input  logic       cmd_rw,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_reg,
   input  logic [7:0] cmd_wdata,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic [7:0] rd_data,
   output logic       SCL,
   inout  wire        SDA
);

   i2c_state_t state_reg, state_next;
   logic [6:0] addr_reg, addr_next;
   logic [7:0] reg_addr_reg, reg_addr_next;
   logic [7:0] wdata_reg, wdata_next;
   logic       rw_reg, rw_next;
   logic [2:0] bit_cnt_reg, bit_cnt_next;
   logic       ack_err_reg, ack_err_next;
   logic       done_reg, done_next;
   logic       sda_smp_reg, sda_smp_next;
   logic       scl_reg, sda_oe_reg;
   logic       scl_c, sda_low_c;
   logic [7:0] tx_byte;
   logic       is_byte, bit_end, last_bit, scl_mid;
   logic       qtr_tick;
   qtr_phase_t phase;

   i2c_qtr_tick #(.QTR_DIV(QTR_DIV)) u_qtr_tick (
      .clk   (clk),
      .reset (reset),
      .en    (state_reg != IDLE),
      .tick  (qtr_tick),
      .phase (phase)
   );

   assign bit_end  = qtr_tick && (phase == Q3);
   assign last_bit = (bit_cnt_reg == 3'd7);
   assign scl_mid  = (phase == Q1) || (phase == Q2);

`ifdef I2C_MASTER_READ_EN
   logic [7:0] rx_shift_reg, rx_shift_next;
   logic [7:0] rd_data_reg, rd_data_next;
   logic       rw_in;
   assign rw_in   = cmd_rw;
   assign rd_data = rd_data_reg;
`else
   logic rw_in;
   logic unused_rw;
   assign unused_rw = cmd_rw;
   assign rw_in     = 1'b0;
   assign rd_data   = 8'h00;
`endif

   always_comb begin
      is_byte = 1'b0;
      case (state_reg)
         ADDR, REG, WDATA: is_byte = 1'b1;
`ifdef I2C_MASTER_READ_EN
         ADDR_RD, RDATA:   is_byte = 1'b1;
`endif
         default:          is_byte = 1'b0;
      endcase
   end

   always_comb begin
      tx_byte = wdata_reg;
      case (state_reg)
         ADDR:    tx_byte = {addr_reg, 1'b0};
         REG:     tx_byte = reg_addr_reg;
`ifdef I2C_MASTER_READ_EN
         ADDR_RD: tx_byte = {addr_reg, 1'b1};
`endif
         default: tx_byte = wdata_reg;
      endcase
   end

   always_comb begin
      state_next    = state_reg;
      addr_next     = addr_reg;
      reg_addr_next = reg_addr_reg;
      wdata_next    = wdata_reg;
      rw_next       = rw_reg;
      bit_cnt_next  = bit_cnt_reg;
      ack_err_next  = ack_err_reg;
      done_next     = 1'b0;
      sda_smp_next  = sda_smp_reg;
`ifdef I2C_MASTER_READ_EN
      rx_shift_next = rx_shift_reg;
      rd_data_next  = rd_data_reg;
`endif
      if (qtr_tick && phase == Q2)
         sda_smp_next = SDA;
      // Counter wraps 7->0 as each byte hands over to its ACK bit
      if (bit_end && is_byte)
         bit_cnt_next = bit_cnt_reg + 3'd1;

      case (state_reg)
         IDLE: begin
            if (cmd_start) begin
               addr_next     = (cmd_addr == ADDR_GENERAL) ? DEF_SLAVE_ADDR : cmd_addr;
               reg_addr_next = cmd_reg;
               wdata_next    = cmd_wdata;
               rw_next       = rw_in;
               bit_cnt_next  = 3'd0;
               ack_err_next  = 1'b0;
               state_next    = START;
            end
         end
         START:     if (bit_end) state_next = ADDR;
         ADDR:      if (bit_end && last_bit) state_next = ACK_ADDR;
         REG:       if (bit_end && last_bit) state_next = ACK_REG;
         WDATA:     if (bit_end && last_bit) state_next = ACK_WDATA;
         ACK_ADDR: begin
            if (bit_end) begin
               if (sda_smp_reg) begin
                  ack_err_next = 1'b1;
                  state_next   = STOP;
               end else begin
                  state_next   = REG;
               end
            end
         end
         ACK_REG: begin
            if (bit_end) begin
               if (sda_smp_reg) begin
                  ack_err_next = 1'b1;
                  state_next   = STOP;
               end else begin
`ifdef I2C_MASTER_READ_EN
                  state_next   = (rw_reg == RW_READ) ? RESTART : WDATA;
`else
                  state_next   = WDATA;
`endif
               end
            end
         end
         ACK_WDATA: begin
            if (bit_end) begin
               if (sda_smp_reg) ack_err_next = 1'b1;
               state_next = STOP;
            end
         end
`ifdef I2C_MASTER_READ_EN
         RESTART:   if (bit_end) state_next = ADDR_RD;
         ADDR_RD:   if (bit_end && last_bit) state_next = ACK_ADDR_RD;
         ACK_ADDR_RD: begin
            if (bit_end) begin
               if (sda_smp_reg) begin
                  ack_err_next = 1'b1;
                  state_next   = STOP;
               end else begin
                  state_next   = RDATA;
               end
            end
         end
         RDATA: begin
            if (qtr_tick && phase == Q2)
               rx_shift_next = {rx_shift_reg[6:0], SDA};
            if (bit_end && last_bit) begin
               rd_data_next = rx_shift_reg;
               state_next   = MNACK;
            end
         end
         MNACK:     if (bit_end) state_next = STOP;
`endif
         STOP: begin
            if (bit_end) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default:   state_next = IDLE;
      endcase
   end

   // START/STOP keep SCL high across the SDA edge; data bits clock in Q1-Q2
   always_comb begin
      scl_c     = 1'b1;
      sda_low_c = 1'b0;
      case (state_reg)
         IDLE: begin
            scl_c     = 1'b1;
            sda_low_c = 1'b0;
         end
         START: begin
            scl_c     = (phase != Q3);
            sda_low_c = (phase == Q2) || (phase == Q3);
         end
         STOP: begin
            scl_c     = (phase != Q0);
            sda_low_c = (phase == Q0) || (phase == Q1);
         end
`ifdef I2C_MASTER_READ_EN
         RESTART: begin
            scl_c     = scl_mid;
            sda_low_c = (phase == Q2) || (phase == Q3);
         end
         ADDR_RD: begin
            scl_c     = scl_mid;
            sda_low_c = !tx_byte[~bit_cnt_reg];
         end
`endif
         ADDR, REG, WDATA: begin
            scl_c     = scl_mid;
            sda_low_c = !tx_byte[~bit_cnt_reg];
         end
         default: begin
            scl_c     = scl_mid;
            sda_low_c = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         reg_addr_reg <= '0;
         wdata_reg    <= '0;
         rw_reg       <= 1'b0;
         bit_cnt_reg  <= '0;
         ack_err_reg  <= 1'b0;
         done_reg     <= 1'b0;
         sda_smp_reg  <= 1'b1;
         scl_reg      <= 1'b1;
         sda_oe_reg   <= 1'b0;
`ifdef I2C_MASTER_READ_EN
         rx_shift_reg <= '0;
         rd_data_reg  <= '0;
`endif
      end else begin
         state_reg    <= state_next;
         addr_reg     <= addr_next;
         reg_addr_reg <= reg_addr_next;
         wdata_reg    <= wdata_next;
         rw_reg       <= rw_next;
         bit_cnt_reg  <= bit_cnt_next;
         ack_err_reg  <= ack_err_next;
         done_reg     <= done_next;
         sda_smp_reg  <= sda_smp_next;
         scl_reg      <= scl_c;
         sda_oe_reg   <= sda_low_c;
`ifdef I2C_MASTER_READ_EN
         rx_shift_reg <= rx_shift_next;
         rd_data_reg  <= rd_data_next;
`endif
      end
   end

   assign busy    = (state_reg != IDLE);
   assign done    = done_reg;
   assign ack_err = ack_err_reg;
   assign SCL     = scl_reg;
   assign SDA     = sda_oe_reg ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: bus-level slave/monitor plus a transaction-level
// expectation model; read checks only when I2C_MASTER_READ_EN is defined.
module tb_i2c_master_ctrl;

   localparam int         QTR      = 4;
   localparam logic [6:0] SLV_ADDR = 7'h55;
   localparam int         EV_START = 256;
   localparam int         EV_STOP  = 257;
   localparam int         EV_ACK   = 512;
`ifdef I2C_MASTER_READ_EN
   localparam bit READ_EN = 1'b1;
`else
   localparam bit READ_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_start = 1'b0;
   logic       cmd_rw = 1'b0;
   logic [6:0] cmd_addr = '0;
   logic [7:0] cmd_reg = '0;
   logic [7:0] cmd_wdata = '0;
   wire        busy, done, ack_err, SCL;
   wire  [7:0] rd_data;
   wire        sda_bus;
   logic       drv = 1'b0;

   pullup (sda_bus);
   assign sda_bus = drv ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_master_ctrl #(.QTR_DIV(QTR), .DEF_SLAVE_ADDR(7'h55)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_start (cmd_start),
      .cmd_rw    (cmd_rw),
      .cmd_addr  (cmd_addr),
      .cmd_reg   (cmd_reg),
      .cmd_wdata (cmd_wdata),
      .busy      (busy),
      .done      (done),
      .ack_err   (ack_err),
      .rd_data   (rd_data),
      .SCL       (SCL),
      .SDA       (sda_bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Bus observation log and slave state
   int         ev_q[$];
   int         exp_q[$];
   int         rises, exp_rises, done_cnt;
   logic [7:0] slave_mem [256];
   logic [7:0] ref_mem   [256];
   logic [7:0] exp_rd = 8'h00;
   logic       exp_err = 1'b0;

   initial begin : slave_model
      logic       scl_q, sda_q, scl_now, sda_now, sel, rd;
      logic [7:0] sh, ptr;
      int         bitn, byte_idx;
      scl_q = 1'b1; sda_q = 1'b1; sel = 1'b0; rd = 1'b0;
      sh = '0; ptr = '0; bitn = 0; byte_idx = 0;
      forever begin
         @(negedge clk);
         scl_now = SCL;
         sda_now = sda_bus;
         if (done === 1'b1) done_cnt++;
         if (reset) begin
            bitn = 0; sel = 1'b0; rd = 1'b0; drv = 1'b0;
         end else if (scl_now && scl_q && sda_q && !sda_now) begin
            ev_q.push_back(EV_START);
            bitn = 0; byte_idx = 0; sel = 1'b0; rd = 1'b0; drv = 1'b0;
         end else if (scl_now && scl_q && !sda_q && sda_now) begin
            ev_q.push_back(EV_STOP);
            sel = 1'b0; rd = 1'b0; drv = 1'b0;
         end else if (scl_now && !scl_q) begin
            rises++;
            if (bitn < 8) sh = {sh[6:0], sda_now};
            else begin
               ev_q.push_back(EV_ACK + int'(sda_now));
               if (sel && rd && byte_idx >= 2 && sda_now) rd = 1'b0;
            end
            bitn++;
         end else if (!scl_now && scl_q) begin
            if (bitn == 8) begin
               ev_q.push_back(int'(sh));
               if (sel && rd && byte_idx >= 1) drv = 1'b0;
               else if (byte_idx == 0) begin
                  sel = (sh[7:1] == SLV_ADDR);
                  rd  = sh[0];
                  drv = sel;
               end else if (sel) begin
                  if (byte_idx == 1) ptr = sh;
                  else slave_mem[ptr] = sh;
                  drv = 1'b1;
               end
               byte_idx++;
            end else if (bitn == 9) begin
               drv  = 1'b0;
               bitn = 0;
               if (sel && rd) drv = !slave_mem[ptr][7];
            end else if (bitn >= 1 && bitn <= 7 && sel && rd && byte_idx >= 1) begin
               drv = !slave_mem[ptr][7 - bitn];
            end
         end
         scl_q = scl_now;
         sda_q = sda_now;
      end
   end

   // Expected bus events for one command, from the protocol sequence alone
   task automatic build_exp(input logic rw, input logic [6:0] addr,
                            input logic [7:0] r, input logic [7:0] w);
      logic [6:0] eff;
      logic       present;
      eff     = (addr == 7'h00) ? 7'h55 : addr;
      present = (eff == SLV_ADDR);
      exp_q.delete();
      exp_q.push_back(EV_START);
      exp_q.push_back(int'({eff, 1'b0}));
      exp_q.push_back(EV_ACK + (present ? 0 : 1));
      exp_rises = 9;
      exp_err   = !present;
      if (present) begin
         exp_q.push_back(int'(r));
         exp_q.push_back(EV_ACK);
         exp_rises += 9;
         if (rw && READ_EN) begin
            exp_q.push_back(EV_START);
            exp_q.push_back(int'({eff, 1'b1}));
            exp_q.push_back(EV_ACK);
            exp_q.push_back(int'(ref_mem[r]));
            exp_q.push_back(EV_ACK + 1);
            exp_rises += 19;
            exp_rd = ref_mem[r];
         end else begin
            exp_q.push_back(int'(w));
            exp_q.push_back(EV_ACK);
            exp_rises += 9;
            ref_mem[r] = w;
         end
      end
      exp_q.push_back(EV_STOP);
      exp_rises += 1;
   endtask

   task automatic run_txn(input logic rw, input logic [6:0] addr, input logic [7:0] r,
                          input logic [7:0] w, input bit collide);
      int n;
      build_exp(rw, addr, r, w);
      ev_q.delete();
      rises = 0;
      done_cnt = 0;
      @(negedge clk);
      cmd_rw = rw; cmd_addr = addr; cmd_reg = r; cmd_wdata = w; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      check("busy_on", busy, 1);
      check("err_clr", ack_err, 0);
      n = 0;
      while (done !== 1'b1 && n < 4000) begin
         if (collide && n == 200) begin
            cmd_start = 1'b1; cmd_wdata = 8'hFF; cmd_reg = 8'h77; cmd_addr = 7'h55;
         end else cmd_start = 1'b0;
         @(negedge clk);
         n++;
      end
      cmd_start = 1'b0;
      check("done_timeout", int'(n < 4000), 1);
      check("busy_at_done", busy, 0);
      @(negedge clk);
      check("done_1cyc", done, 0);
      @(negedge clk);
      check("done_count", done_cnt, 1);
      check("ev_count", ev_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
         check($sformatf("bus_ev%0d", i), ev_q[i], exp_q[i]);
      check("scl_rises", rises, exp_rises);
      check("ack_err", ack_err, exp_err);
      check("rd_data", rd_data, exp_rd);
      $display("TXN rw=%0d addr=%02h reg=%02h wdata=%02h collide=%0d ack_err=%0d rd_data=%02h events=%0d",
               rw, addr, r, w, collide, ack_err, rd_data, ev_q.size());
   endtask

   task automatic run_abort(input logic [7:0] r, input logic [7:0] w);
      int stops;
      ev_q.delete();
      @(negedge clk);
      cmd_rw = 1'b0; cmd_addr = 7'h55; cmd_reg = r; cmd_wdata = w; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      // 19 bit times precede WDATA; land inside its bit 4
      repeat (374) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      check("pre_rst_ev", ev_q.size(), 5);
      reset = 1'b1;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_scl", SCL, 1);
      check("rst_sda", sda_bus, 1);
      stops = 0;
      foreach (ev_q[i]) if (ev_q[i] == EV_STOP) stops++;
      check("rst_no_stop", stops, 0);
      reset = 1'b0;
      exp_rd  = 8'h00;
      exp_err = 1'b0;
      check("rst_rd_data", rd_data, 0);
      $display("TXN abort reg=%02h wdata=%02h busy=%0d SCL=%0d SDA=%0d", r, w, busy, SCL, sda_bus);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         slave_mem[i] = 8'($urandom);
         ref_mem[i]   = slave_mem[i];
      end
      slave_mem[0] = 8'h7E;
      ref_mem[0]   = 8'h7E;

      repeat (3) @(negedge clk);
      check("rst_busy0", busy, 0);
      check("rst_done0", done, 0);
      check("rst_err0", ack_err, 0);
      check("rst_rd0", rd_data, 0);
      check("rst_scl0", SCL, 1);
      check("rst_sda0", sda_bus, 1);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_scl", SCL, 1);

      run_txn(1'b0, 7'h55, 8'h02, 8'h03, 1'b0);
      if (READ_EN) run_txn(1'b1, 7'h55, 8'h00, 8'h00, 1'b0);
      else         run_txn(1'b1, 7'h55, 8'h00, 8'h5A, 1'b0);
      run_txn(1'b0, 7'h11, 8'h02, 8'h03, 1'b0);
      run_txn(1'b0, 7'h55, 8'h10, 8'h3C, 1'b1);
      run_abort(8'h20, 8'hC5);
      run_txn(1'b0, 7'h55, 8'h21, 8'h96, 1'b0);

      for (int k = 0; k < 12; k++) begin
         logic [6:0] a;
         case ($urandom_range(0, 3))
            0:       a = 7'h55;
            1:       a = 7'h00;
            2:       a = 7'($urandom);
            default: a = 7'h55;
         endcase
         run_txn(1'($urandom_range(0, 1)), a, 8'($urandom), 8'($urandom), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
